// File: rtl/mem_stage.sv
// Memory stage: variable-latency data-memory access plus the MEM/WB register.
// Optional watchdog that aborts unacknowledged accesses: define MEM_TIMEOUT_EN.

package mem_stage_pkg;

  typedef struct packed {
    logic [15:0] aluResult;
    logic [15:0] memData;
    logic [3:0]  wrReg;
    logic        halt;
    logic        regWrite;
    logic        memToReg;
  } memWb_t;

endpackage

module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_M,
  input  logic [15:0] alu_result_M,
  input  logic [15:0] store_data_M,
  input  logic [3:0]  wr_reg_M,
  input  logic        halt_M,
  input  logic        reg_write_M,
  input  logic        mem_to_reg_M,
  input  logic        mem_read_M,
  input  logic        mem_write_M,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [15:0] dmem_rdata,
  output logic        stall_M,
  output logic [38:0] W_out,
`ifdef MEM_TIMEOUT_EN
  output logic        mem_err,
`endif
  output logic        halted_M
);

  typedef enum logic {IDLE, WAIT} stateT;

  stateT  state;
  stateT  nextState;
  memWb_t wbQ;
  memWb_t wbNext;
  logic   haltedQ;
  logic   memOp;
  logic   complete;
  logic   loadBundle;
  logic   timeoutHit;

  // A memory op is never seen while in reset, so dmem_req drops with rst_n.
  assign memOp = rst_n && valid_M && !haltedQ && (mem_read_M || mem_write_M);

  assign dmem_addr  = alu_result_M;
  assign dmem_wdata = store_data_M;
  assign dmem_we    = dmem_req && mem_write_M;
  assign W_out      = wbQ;
  assign halted_M   = haltedQ;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] waitCnt;
  logic             memErrQ;

  // The abort fires in the WAIT cycle that would bring the count to TIMEOUT_CYCLES.
  assign timeoutHit = (state == WAIT) && !dmem_ack &&
                      (waitCnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign mem_err    = memErrQ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waitCnt <= '0;
      memErrQ <= 1'b0;
    end else begin
      if (state == IDLE) begin
        waitCnt <= '0;
      end else if (!dmem_ack) begin
        waitCnt <= waitCnt + CNT_W'(1);
      end
      if (timeoutHit) begin
        memErrQ <= 1'b1;
      end
    end
  end
`else
  assign timeoutHit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Handshake, stall and completion decode.
  always_comb begin
    nextState = state;
    dmem_req  = 1'b0;
    stall_M   = 1'b0;
    complete  = 1'b0;
    case (state)
      IDLE: begin
        if (memOp) begin
          dmem_req = 1'b1;
          if (dmem_ack) begin
            complete = 1'b1;
          end else begin
            stall_M   = 1'b1;
            nextState = WAIT;
          end
        end else begin
          complete = 1'b1;
        end
      end
      WAIT: begin
        if (dmem_ack) begin
          dmem_req  = 1'b1;
          complete  = 1'b1;
          nextState = IDLE;
        end else if (timeoutHit) begin
          nextState = IDLE;
        end else begin
          dmem_req = 1'b1;
          stall_M  = 1'b1;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  assign loadBundle = complete && valid_M && !haltedQ;

  // Next MEM/WB contents; anything that does not complete becomes a bubble.
  always_comb begin
    wbNext = '0;
    if (loadBundle) begin
      wbNext.aluResult = alu_result_M;
      wbNext.memData   = (mem_read_M && !mem_write_M) ? dmem_rdata : 16'h0000;
      wbNext.wrReg     = wr_reg_M;
      wbNext.halt      = halt_M;
      wbNext.regWrite  = reg_write_M;
      wbNext.memToReg  = mem_to_reg_M;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbQ     <= '0;
      haltedQ <= 1'b0;
    end else begin
      wbQ <= wbNext;
      if (wbNext.halt) begin
        haltedQ <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage (timeout steps need MEM_TIMEOUT_EN).

module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_M;
  logic [15:0] alu_result_M;
  logic [15:0] store_data_M;
  logic [3:0]  wr_reg_M;
  logic        halt_M;
  logic        reg_write_M;
  logic        mem_to_reg_M;
  logic        mem_read_M;
  logic        mem_write_M;
  logic        dmem_req;
  logic        dmem_we;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic        dmem_ack;
  logic [15:0] dmem_rdata;
  logic        stall_M;
  logic [38:0] W_out;
  logic        halted_M;
`ifdef MEM_TIMEOUT_EN
  logic        mem_err;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

`ifdef MEM_TIMEOUT_EN
  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
`else
  mem_stage dut (
`endif
    .clk(clk), .rst_n(rst_n), .valid_M(valid_M), .alu_result_M(alu_result_M),
    .store_data_M(store_data_M), .wr_reg_M(wr_reg_M), .halt_M(halt_M),
    .reg_write_M(reg_write_M), .mem_to_reg_M(mem_to_reg_M),
    .mem_read_M(mem_read_M), .mem_write_M(mem_write_M),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stall_M(stall_M), .W_out(W_out),
`ifdef MEM_TIMEOUT_EN
    .mem_err(mem_err),
`endif
    .halted_M(halted_M)
  );

  task automatic chk(input string tag, input logic [38:0] obs, input logic [38:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearIn();
    valid_M = 0; alu_result_M = 0; store_data_M = 0; wr_reg_M = 0;
    halt_M = 0; reg_write_M = 0; mem_to_reg_M = 0; mem_read_M = 0;
    mem_write_M = 0; dmem_ack = 0; dmem_rdata = 0;
  endtask

  initial begin
    rst_n = 0;
    clearIn();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_wout", W_out, 39'h0);
    chk("reset_halted", 39'(halted_M), 39'h0);
    chk("reset_req", 39'(dmem_req), 39'h0);
    chk("reset_stall", 39'(stall_M), 39'h0);
    rst_n = 1;
    tick();

    // ALU op passes straight through
    valid_M = 1; alu_result_M = 16'h1234; wr_reg_M = 4'd5; reg_write_M = 1;
    #1;
    chk("alu_req", 39'(dmem_req), 39'h0);
    chk("alu_stall", 39'(stall_M), 39'h0);
    tick();
    chk("alu_wout", W_out, {16'h1234, 16'h0000, 4'd5, 1'b0, 1'b1, 1'b0});

    // Load acked 3 cycles after the request cycle
    alu_result_M = 16'h0040; mem_read_M = 1; mem_to_reg_M = 1; wr_reg_M = 4'd3;
    #1;
    chk("ld_req", 39'(dmem_req), 39'h1);
    chk("ld_we", 39'(dmem_we), 39'h0);
    chk("ld_addr", 39'(dmem_addr), 39'h0040);
    chk("ld_stall0", 39'(stall_M), 39'h1);
    tick();
    chk("ld_bubble0", W_out, 39'h0);
    chk("ld_stall1", 39'(stall_M), 39'h1);
    chk("ld_req1", 39'(dmem_req), 39'h1);
    tick();
    chk("ld_bubble1", W_out, 39'h0);
    chk("ld_stall2", 39'(stall_M), 39'h1);
    chk("ld_req2", 39'(dmem_req), 39'h1);
    tick();
    chk("ld_bubble2", W_out, 39'h0);
    dmem_ack = 1; dmem_rdata = 16'hBEEF;
    #1;
    chk("ld_stall_ack", 39'(stall_M), 39'h0);
    chk("ld_req_ack", 39'(dmem_req), 39'h1);
    tick();
    chk("ld_wout", W_out, {16'h0040, 16'hBEEF, 4'd3, 1'b0, 1'b1, 1'b1});

    // Back-to-back store, acked in the request cycle
    mem_read_M = 0; mem_write_M = 1; mem_to_reg_M = 0; reg_write_M = 0;
    wr_reg_M = 4'd0; alu_result_M = 16'h0080; store_data_M = 16'h00FF;
    #1;
    chk("st_req", 39'(dmem_req), 39'h1);
    chk("st_we", 39'(dmem_we), 39'h1);
    chk("st_wdata", 39'(dmem_wdata), 39'h00FF);
    chk("st_stall", 39'(stall_M), 39'h0);
    tick();
    chk("st_wout", W_out, {16'h0080, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0});

    // Stray ack on a non-memory op is ignored
    mem_write_M = 0; reg_write_M = 1; wr_reg_M = 4'd7; alu_result_M = 16'h0009;
    dmem_rdata = 16'hFFFF;
    #1;
    chk("stray_req", 39'(dmem_req), 39'h0);
    chk("stray_we", 39'(dmem_we), 39'h0);
    tick();
    chk("stray_wout", W_out, {16'h0009, 16'h0000, 4'd7, 1'b0, 1'b1, 1'b0});

    // Read and write together: write wins, mem_data is zero
    mem_read_M = 1; mem_write_M = 1; mem_to_reg_M = 1; wr_reg_M = 4'd2;
    alu_result_M = 16'h0100; dmem_rdata = 16'hAAAA;
    #1;
    chk("rw_we", 39'(dmem_we), 39'h1);
    tick();
    chk("rw_wout", W_out, {16'h0100, 16'h0000, 4'd2, 1'b0, 1'b1, 1'b1});

    // Asynchronous reset while waiting
    mem_write_M = 0; dmem_ack = 0; alu_result_M = 16'h0200;
    tick();
    chk("rst_wait_stall", 39'(stall_M), 39'h1);
    rst_n = 0;
    #1;
    chk("rst_wait_req", 39'(dmem_req), 39'h0);
    chk("rst_wait_stall0", 39'(stall_M), 39'h0);
    chk("rst_wait_wout", W_out, 39'h0);
    clearIn();
    #1;
    rst_n = 1;
    tick();
    chk("rst_rel_wout", W_out, 39'h0);
    chk("rst_rel_halted", 39'(halted_M), 39'h0);
    chk("rst_rel_req", 39'(dmem_req), 39'h0);

`ifdef MEM_TIMEOUT_EN
    // Load never acknowledged: aborted in the 4th WAIT cycle
    valid_M = 1; mem_read_M = 1; mem_to_reg_M = 1; reg_write_M = 1;
    wr_reg_M = 4'd4; alu_result_M = 16'h0300;
    #1;
    chk("to_stall0", 39'(stall_M), 39'h1);
    tick();
    for (int i = 1; i <= 3; i++) begin
      chk("to_stall_wait", 39'(stall_M), 39'h1);
      chk("to_req_wait", 39'(dmem_req), 39'h1);
      chk("to_err_wait", 39'(mem_err), 39'h0);
      tick();
    end
    chk("to_stall_abort", 39'(stall_M), 39'h0);
    chk("to_req_abort", 39'(dmem_req), 39'h0);
    tick();
    chk("to_wout", W_out, 39'h0);
    chk("to_err", 39'(mem_err), 39'h1);
    mem_read_M = 0; mem_to_reg_M = 0; wr_reg_M = 4'd1; alu_result_M = 16'h0005;
    #1;
    chk("to_next_stall", 39'(stall_M), 39'h0);
    tick();
    chk("to_next_wout", W_out, {16'h0005, 16'h0000, 4'd1, 1'b0, 1'b1, 1'b0});
    chk("to_err_sticky", 39'(mem_err), 39'h1);
`endif

    // Halt, then a load that must be suppressed
    clearIn();
    valid_M = 1; halt_M = 1;
    tick();
    chk("halt_flag", 39'(halted_M), 39'h1);
    chk("halt_wout", W_out, {16'h0000, 16'h0000, 4'd0, 1'b1, 1'b0, 1'b0});
    halt_M = 0; mem_read_M = 1; mem_to_reg_M = 1; reg_write_M = 1;
    alu_result_M = 16'h0040; wr_reg_M = 4'd3;
    #1;
    chk("halt_ld_req", 39'(dmem_req), 39'h0);
    chk("halt_ld_stall", 39'(stall_M), 39'h0);
    tick();
    chk("halt_ld_wout", W_out, 39'h0);
    dmem_ack = 1; dmem_rdata = 16'h1111;
    tick();
    chk("halt_ld_wout2", W_out, 39'h0);
    chk("halt_sticky", 39'(halted_M), 39'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the 16-bit pipelined core, between the EX/MEM pipeline register and the writeback stage. It issues data-memory reads and writes over a variable-latency request/acknowledge interface and stalls the upstream pipeline while an access is outstanding. It also owns the MEM/WB pipeline register, and presents a packed 39-bit bundle that writeback consumes directly. An optional watchdog aborts accesses the memory never acknowledges.

## Interface
- TIMEOUT_CYCLES, 15: the number of WAIT cycles allowed without an acknowledge before the access is aborted. Used only with MEM_TIMEOUT_EN.
- clk  in  1  the core clock. All state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- valid_M  in  1  the EX/MEM slot holds a real instruction.
- alu_result_M  in  16  the ALU result. It is also the memory address.
- store_data_M  in  16  the data to store.
- wr_reg_M  in  4  the destination register.
- halt_M, reg_write_M, mem_to_reg_M  in  1 each  control bits passed through to writeback.
- mem_read_M, mem_write_M  in  1 each  memory operation select.
- dmem_req  out  1  data-memory request.
- dmem_we  out  1  write enable. Valid only while dmem_req=1.
- dmem_addr  out  16  address. Equals alu_result_M.
- dmem_wdata  out  16  write data. Equals store_data_M.
- dmem_ack  in  1  the access completes this cycle.
- dmem_rdata  in  16  read data. Valid when dmem_ack=1.
- stall_M  out  1  upstream must hold the EX/MEM register and all earlier stages.
- W_out  out  39  the MEM/WB register, packed as {alu_result[15:0], mem_data[15:0], wr_reg[3:0], halt, reg_write, mem_to_reg}.
- halted_M  out  1  sticky; set once a halting instruction has entered W_out.
- mem_err  out  1  sticky timeout flag. Present only with MEM_TIMEOUT_EN.

## Operation
- An instruction is a memory op when valid_M=1, halted_M=0 and (mem_read_M or mem_write_M) is set.
- If both mem_read_M and mem_write_M are set, the write takes priority: dmem_we=1 and mem_data is 0.
- The FSM has two states, IDLE and WAIT.
- IDLE, memory op present:
  - dmem_req=1 combinationally.
  - If dmem_ack=1 in the same cycle, the access completes with zero wait and no stall.
  - Otherwise stall_M=1 and the next state is WAIT.
- IDLE, non-memory op: the instruction passes through in one cycle, dmem_req=0 and stall_M=0.
- WAIT:
  - dmem_req=1, with dmem_we, dmem_addr and dmem_wdata held from the stable upstream inputs.
  - stall_M=1 until the dmem_ack cycle. In that cycle stall_M=0 and the next state is IDLE.
- W_out load rules, applied on each rising edge:
  - Instruction completes (non-memory op, or memory op with dmem_ack=1): load {alu_result_M, mem_data, wr_reg_M, halt_M, reg_write_M, mem_to_reg_M}.
  - mem_data is dmem_rdata for reads and 16'h0000 otherwise.
  - stall_M=1, valid_M=0, or halted_M=1: load a bubble (all 39 bits zero). Writeback therefore never re-commits a stalled instruction.
- halted_M sets on the edge that loads a bundle with halt=1.
  - After that, every input is treated as a bubble and no dmem_req is issued.
  - Only reset clears halted_M.

## Timing
- Reset values: W_out=0, halted_M=0, mem_err=0, state IDLE, dmem_req=0, stall_M=0.
- Latency:
  - Non-memory op, or memory op acknowledged in the request cycle: 1 cycle from EX/MEM to W_out.
  - Memory op acknowledged N cycles after the request cycle: N+1 cycles.
  - stall_M is high for exactly N cycles.
- Handshake:
  - dmem_req stays high continuously from issue until ack.
  - dmem_ack seen while dmem_req=0 is ignored.
  - Back-to-back memory ops issue a new request in the cycle immediately after the previous ack.
- Asynchronous reset during WAIT:
  - Returns to IDLE and drops dmem_req and stall_M immediately.
  - Any in-flight memory response is ignored.

## Configuration
- MEM_TIMEOUT_EN defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) is cleared on entry to WAIT and increments each WAIT cycle without ack.
  - When it reaches TIMEOUT_CYCLES without an ack, in that cycle: dmem_req=0, stall_M=0, a bubble loads into W_out, mem_err sets (sticky), and the next state is IDLE.
  - An ack arriving in the same cycle as the timeout wins: the access completes normally and mem_err is not set.
- MEM_TIMEOUT_EN undefined: no counter and no mem_err port. WAIT lasts indefinitely until ack.

## Test plan
- Reset: hold rst_n=0 mid-WAIT -> dmem_req=0 and stall_M=0 immediately. After release, W_out=39'h0 and halted_M=0.
- ALU op, alu_result_M=16'h1234, wr_reg_M=4'd5, reg_write_M=1 -> next cycle W_out={16'h1234, 16'h0000, 4'd5, 0, 1, 0}, with no stall.
- Load from 16'h0040, ack 3 cycles after the request cycle with rdata=16'hBEEF -> stall_M high for 3 cycles, bubbles in W_out meanwhile, then mem_data=16'hBEEF and mem_to_reg=1.
- Store to 16'h0080 with data 16'h00FF, ack in the request cycle -> dmem_we=1 for one cycle, no stall, and W_out has reg_write=0 and mem_data=0.
- Halt instruction followed by a load -> halted_M=1 after one cycle. The later load issues no dmem_req and W_out stays 0 thereafter.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, a load that is never acknowledged -> stall_M drops and mem_err=1 at the 4th WAIT cycle, a bubble enters W_out, and the next instruction proceeds.
